sub4_rr_sched: RTL and testbench
================================

Name: sub4_rr_sched

Overview:
- Round-robin scheduler that shares one W-bit add/subtract unit (the Ch07 sub4 datapath) among four requesters.
- Each requester presents two operands and an op code, then holds its request until acknowledged.
- The block arbitrates, latches the winner's operands, computes a (W+1)-bit result and returns it with a one-cycle ack.
- Sits between the exercise's operand sources and the shared arithmetic resource.

Parameters:
- W, 4, operand width; result is W+1 bits.
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req  in  4  request per requester; bit i = requester i.
- op_a  in  4*W  operand A of requester i in bits [i*W +: W].
- op_b  in  4*W  operand B of requester i in bits [i*W +: W].
- mode  in  4  per-requester op: 0 = A+B, 1 = A-B.
- ack  out  4  one-hot, one-cycle pulse to the served requester.
- result  out  W+1  result of the last operation; held until the next one completes.
- res_valid  out  1  high in the same cycle as ack.
- grant_id  out  2  index of the requester currently or last granted.
- busy  out  1  high in LOAD, EXEC and RESP.
- op_count  out  CNT_W  number of completed operations; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst_n low at a clk edge) clears all state:
  - ack=0, res_valid=0, result=0, grant_id=0, busy=0, op_count=0, FSM=IDLE.
  - Round-robin pointer last=3, so requester 0 has highest priority first.
- FSM states are IDLE, LOAD, EXEC, RESP. No state stays longer than one cycle except IDLE.
- IDLE:
  - If req!=0, select the first set bit searching last+1, last+2, ... modulo 4.
  - Register that index into grant_id and go to LOAD.
  - If req==0, stay in IDLE.
- LOAD: latch op_a, op_b and mode of grant_id into internal registers; go to EXEC.
- EXEC: compute from the latched values and register into result.
  - add: {1'b0,A}+{1'b0,B}.
  - sub: ({1'b0,A}-{1'b0,B}) mod 2^(W+1), i.e. two's complement; result[W] is borrow/sign.
  - Go to RESP.
- RESP:
  - ack[grant_id]=1, res_valid=1, op_count+=1, last=grant_id.
  - Go to IDLE.
- Latency: req sampled in IDLE at edge t -> ack/res_valid high in cycle t+3.
  - Throughput is at most one operation per 4 cycles.
- Requester rules:
  - Hold req, operands and mode stable from assertion until ack.
  - Deassert req in the cycle after ack, unless issuing a back-to-back request.
- Operand changes after LOAD have no effect on the current operation.
- req dropped before ack: the operation completes anyway; ack still pulses; the result is delivered.
- req re-asserted immediately after ack: eligible again in the next IDLE, but ranked lowest by the round-robin order.
- Simultaneous requests: exactly one grant per cycle through IDLE; no requester waits more than 3 other operations.
- rst_n low in any state aborts the operation: no ack, no op_count increment, all outputs go to reset values.
- op_count wraps from 2^CNT_W-1 to 0 without a flag.
- ack is never asserted for more than one bit or more than one cycle per operation.

Decomposition:
- Package sub4_sched_pkg:
  - state enum {IDLE, LOAD, EXEC, RESP}.
  - op codes OP_ADD=1'b0, OP_SUB=1'b1.
  - N_REQ=4 constant.
- Sub-module addsub_unit (combinational):
  - Inputs W-bit a, b and 1-bit sub; output W+1 result.
  - Instantiated once; the scheduler owns all registers.
- Round-robin select: a function in the top level, not a separate module.

Test Plan:
- Reset check: hold rst_n=0 for 3 cycles, then release -> ack=0, res_valid=0, result=0, grant_id=0, busy=0, op_count=0.
- Subtraction, positive result: req[0]=1, A=0101, B=0010, mode=1 -> ack[0] and res_valid exactly 3 cycles after the sampling edge, result=00011, op_count=1.
- Subtraction, negative result: req[1]=1, A=0001, B=0110, mode=1 -> result=11011 (-5); add with A=1110, B=1111, mode=0 -> result=11101 (29).
- Arbitration fairness: all four requesters held high with distinct operands -> acks in order 0,1,2,3, one every 4 cycles; then req[0] alone -> granted 0; op_count=5.
- Mid-operation reset and pointer reset: req[2] raised, rst_n=0 during EXEC -> no ack; outputs return to reset values. Then req[2] and req[0] together -> 0 granted first.
- Wrap and stability: 256 back-to-back operations -> op_count wraps to 0; change op_a during EXEC -> the result uses the values latched at LOAD.

Source files
------------

// File: rtl/sub4_sched_pkg.sv
// Shared types and constants for the four-way round-robin add/subtract scheduler.
package sub4_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EXEC = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic        OP_ADD = 1'b0;
  localparam logic        OP_SUB = 1'b1;
  localparam int unsigned N_REQ  = 4;

endpackage

// File: rtl/sub4_rr_sched_addsub.sv
// Combinational W-bit add/subtract; the (W+1)-bit result carries the carry or borrow/sign.
module addsub_unit
  import sub4_sched_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_sub,
  output logic [W:0]   o_result
);

  assign o_result = (i_sub == OP_SUB) ? ({1'b0, i_a} - {1'b0, i_b})
                                      : ({1'b0, i_a} + {1'b0, i_b});

endmodule

// File: rtl/sub4_rr_sched.sv
// Four-requester round-robin scheduler sharing one add/subtract unit.
// Each operation walks IDLE -> LOAD -> EXEC -> RESP; ack/res_valid pulse in RESP.
module sub4_rr_sched
  import sub4_sched_pkg::*;
#(
  parameter int unsigned W     = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] op_a,
  input  logic [N_REQ*W-1:0] op_b,
  input  logic [N_REQ-1:0]   mode,
  output logic [N_REQ-1:0]   ack,
  output logic [W:0]         result,
  output logic               res_valid,
  output logic [1:0]         grant_id,
  output logic               busy,
  output logic [CNT_W-1:0]   op_count
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [1:0]         r_grant;
  logic [1:0]         r_last;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic               r_sub;
  logic [W:0]         r_result;
  logic [CNT_W-1:0]   r_cnt;
  logic [W:0]         w_sum;
  logic [N_REQ-1:0]   w_ack;
  logic               w_busy;
  logic               w_res_valid;

  // First set request searching last+1, last+2, ... with modulo-4 wrap.
  function automatic logic [1:0] rr_pick(input logic [N_REQ-1:0] r, input logic [1:0] last);
    logic [1:0] idx;
    logic       found;
    rr_pick = last;
    found   = 1'b0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = last + 2'(k);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  addsub_unit #(.W(W)) u_addsub (
    .i_a      (r_a),
    .i_b      (r_b),
    .i_sub    (r_sub),
    .o_result (w_sum)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_last   <= 2'd3;
      r_a      <= '0;
      r_b      <= '0;
      r_sub    <= OP_ADD;
      r_result <= '0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: if (|req) r_grant <= rr_pick(req, r_last);
        LOAD: begin
          r_a   <= op_a[r_grant*W +: W];
          r_b   <= op_b[r_grant*W +: W];
          r_sub <= mode[r_grant];
        end
        EXEC: r_result <= w_sum;
        RESP: begin
          r_cnt  <= r_cnt + CNT_W'(1);
          r_last <= r_grant;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ack       = '0;
    w_busy      = 1'b0;
    w_res_valid = 1'b0;
    case (r_state)
      IDLE: if (|req) w_state_nxt = LOAD;
      LOAD: begin
        w_busy      = 1'b1;
        w_state_nxt = EXEC;
      end
      EXEC: begin
        w_busy      = 1'b1;
        w_state_nxt = RESP;
      end
      RESP: begin
        w_busy         = 1'b1;
        w_res_valid    = 1'b1;
        w_ack[r_grant] = 1'b1;
        w_state_nxt    = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign ack       = w_ack;
  assign res_valid = w_res_valid;
  assign busy      = w_busy;
  assign result    = r_result;
  assign grant_id  = r_grant;
  assign op_count  = r_cnt;

endmodule

// File: tb/tb_sub4_rr_sched.sv
// Self-checking bench for sub4_rr_sched: scenario tasks plus a response scoreboard.
module tb_sub4_rr_sched;

  typedef struct packed {
    logic [1:0] id;
    logic [4:0] res;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [3:0]  mode;
  logic [3:0]  ack;
  logic [4:0]  result;
  logic        res_valid;
  logic [1:0]  grant_id;
  logic        busy;
  logic [7:0]  op_count;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic [3:0] prev_ack = '0;

  sub4_rr_sched #(.W(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .op_a      (op_a),
    .op_b      (op_b),
    .mode      (mode),
    .ack       (ack),
    .result    (result),
    .res_valid (res_valid),
    .grant_id  (grant_id),
    .busy      (busy),
    .op_count  (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  function automatic logic [4:0] calc(input logic [3:0] a, input logic [3:0] b, input logic m);
    logic [4:0] ea;
    logic [4:0] eb;
    ea = {1'b0, a};
    eb = {1'b0, b};
    calc = m ? (ea + ~eb + 5'd1) : (ea + eb);
  endfunction

  // Scoreboard: every response must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && (ack !== 4'b0 || res_valid !== 1'b0)) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected ack=%b res_valid=%b result=%b", ack, res_valid, result);
      end else begin
        mon_e = sb.pop_front();
        if (ack !== (4'b0001 << mon_e.id) || res_valid !== 1'b1 || result !== mon_e.res) begin
          failures++;
          $display("FAIL sb_resp got ack=%b rv=%b result=%b expected ack=%b rv=1 result=%b",
                   ack, res_valid, result, 4'b0001 << mon_e.id, mon_e.res);
        end
      end
      checks++;
      if (prev_ack !== 4'b0) begin
        failures++;
        $display("FAIL ack_one_cycle ack=%b prev=%b expected prev=0000", ack, prev_ack);
      end
    end
    prev_ack = ack;
  end

  task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b, input logic m);
    op_a[i*4 +: 4] = a;
    op_b[i*4 +: 4] = b;
    mode[i]        = m;
    req[i]         = 1'b1;
  endtask

  task automatic push(input int i, input logic [4:0] r);
    exp_t e;
    e.id  = 2'(i);
    e.res = r;
    sb.push_back(e);
  endtask

  // Returns negedges counted until ack[idx]; 99 if it never arrives.
  task automatic wait_ack(input int idx, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack[idx] !== 1'b1 && n < 20);
    if (ack[idx] !== 1'b1) n = 99;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (ack !== 4'b0 || res_valid !== 1'b0 || result !== 5'b0 || grant_id !== 2'd0 ||
        busy !== 1'b0 || op_count !== 8'd0) begin
      failures++;
      $display("FAIL reset_state ack=%b rv=%b result=%b gid=%0d busy=%b cnt=%0d expected all zero",
               ack, res_valid, result, grant_id, busy, op_count);
    end
  endtask

  task automatic test_sub_pos();
    int n;
    set_req(0, 4'b0101, 4'b0010, 1'b1);
    push(0, 5'b00011);
    wait_ack(0, n);
    checks++;
    if (n !== 3) begin
      failures++;
      $display("FAIL sub_pos_latency got=%0d expected=3", n);
    end
    req[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (op_count !== 8'd1 || result !== 5'b00011 || busy !== 1'b0 || ack !== 4'b0) begin
      failures++;
      $display("FAIL sub_pos_after cnt=%0d result=%b busy=%b ack=%b expected cnt=1 result=00011 busy=0 ack=0000",
               op_count, result, busy, ack);
    end
  endtask

  task automatic test_sub_neg_add();
    int n;
    set_req(1, 4'b0001, 4'b0110, 1'b1);
    push(1, 5'b11011);
    wait_ack(1, n);
    checks++;
    if (n !== 3) begin
      failures++;
      $display("FAIL sub_neg_latency got=%0d expected=3", n);
    end
    set_req(1, 4'b1110, 4'b1111, 1'b0);
    push(1, 5'b11101);
    wait_ack(1, n);
    checks++;
    if (n !== 4) begin
      failures++;
      $display("FAIL add_b2b_latency got=%0d expected=4", n);
    end
    req[1] = 1'b0;
    @(negedge clk);
    checks++;
    if (op_count !== 8'd3 || result !== 5'b11101) begin
      failures++;
      $display("FAIL add_after cnt=%0d result=%b expected cnt=3 result=11101", op_count, result);
    end
  endtask

  task automatic test_fairness();
    int n;
    logic [3:0] a;
    logic [3:0] b;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      a = 4'(i + 3);
      b = 4'(2 * i + 1);
      set_req(i, a, b, i[0]);
      push(i, calc(a, b, i[0]));
    end
    push(0, calc(4'd3, 4'd1, 1'b0));
    for (int k = 0; k < 4; k++) begin
      wait_ack(k, n);
      checks++;
      if (n !== ((k == 0) ? 3 : 4) || grant_id !== 2'(k)) begin
        failures++;
        $display("FAIL fair_order k=%0d gap=%0d gid=%0d expected gap=%0d gid=%0d",
                 k, n, grant_id, (k == 0) ? 3 : 4, k);
      end
    end
    req = 4'b0001;
    wait_ack(0, n);
    checks++;
    if (n !== 4 || grant_id !== 2'd0) begin
      failures++;
      $display("FAIL fair_solo gap=%0d gid=%0d expected gap=4 gid=0", n, grant_id);
    end
    req = '0;
    @(negedge clk);
    checks++;
    if (op_count !== 8'd5) begin
      failures++;
      $display("FAIL fair_count got=%0d expected=5", op_count);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    set_req(2, 4'd9, 4'd4, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_busy got=%b expected=1", busy);
    end
    rst_n = 1'b0;
    req   = '0;
    @(negedge clk);
    checks++;
    if (ack !== 4'b0 || res_valid !== 1'b0 || result !== 5'b0 || grant_id !== 2'd0 ||
        busy !== 1'b0 || op_count !== 8'd0) begin
      failures++;
      $display("FAIL mid_reset_state ack=%b rv=%b result=%b gid=%0d busy=%b cnt=%0d expected all zero",
               ack, res_valid, result, grant_id, busy, op_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_req(2, 4'd7, 4'd7, 1'b1);
    set_req(0, 4'd8, 4'd8, 1'b0);
    push(0, 5'b10000);
    push(2, 5'b00000);
    wait_ack(0, n);
    checks++;
    if (n !== 3 || grant_id !== 2'd0) begin
      failures++;
      $display("FAIL ptr_reset_first gap=%0d gid=%0d expected gap=3 gid=0", n, grant_id);
    end
    req[0] = 1'b0;
    wait_ack(2, n);
    checks++;
    if (n !== 4 || grant_id !== 2'd2) begin
      failures++;
      $display("FAIL ptr_reset_second gap=%0d gid=%0d expected gap=4 gid=2", n, grant_id);
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_stability();
    int n;
    set_req(1, 4'd9, 4'd3, 1'b1);
    push(1, 5'b00110);
    @(negedge clk);
    @(negedge clk);
    op_a[7:4] = 4'hF;
    op_b[7:4] = 4'h0;
    mode[1]   = 1'b0;
    wait_ack(1, n);
    checks++;
    if (n !== 1 || result !== 5'b00110) begin
      failures++;
      $display("FAIL stability gap=%0d result=%b expected gap=1 result=00110", n, result);
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back_wrap();
    int n;
    logic [3:0] a;
    logic [3:0] b;
    logic       m;
    do_reset();
    for (int k = 0; k < 256; k++) begin
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      m = 1'($urandom_range(0, 1));
      set_req(3, a, b, m);
      push(3, calc(a, b, m));
      wait_ack(3, n);
      checks++;
      if (n !== ((k == 0) ? 3 : 4) || op_count !== 8'(k)) begin
        failures++;
        $display("FAIL b2b k=%0d gap=%0d cnt=%0d expected gap=%0d cnt=%0d",
                 k, n, op_count, (k == 0) ? 3 : 4, k);
      end
    end
    req = '0;
    @(negedge clk);
    checks++;
    if (op_count !== 8'd0) begin
      failures++;
      $display("FAIL wrap_count got=%0d expected=0", op_count);
    end
    checks++;
    if (sb.size() !== 0) begin
      failures++;
      $display("FAIL sb_drain pending=%0d expected=0", sb.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    op_a  = '0;
    op_b  = '0;
    mode  = '0;
    test_reset();
    test_sub_pos();
    test_sub_neg_add();
    test_fairness();
    test_mid_reset();
    test_stability();
    test_back_to_back_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
